alu_pipe: RTL

Parametrised, multi-stage pipelined integer ALU with valid/ready handshakes on both sides. It is the execute unit of the next-generation core: it replaces the fixed 16-bit, free-running ALU and carries a destination tag through to writeback. It also provides backpressure, flush, and a condition-code register updated only on retired results.

---
 rtl/alu_pipe_pkg.sv | 28 ++
 rtl/alu_pipe_core.sv | 41 ++++
 rtl/alu_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: opcodes, condition-code bit positions
// and the per-stage control payload carried alongside result and tag.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ANY = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;

  localparam int CC_ZERO  = 0;
  localparam int CC_NEG   = 1;
  localparam int CC_CARRY = 2;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic       err;
    logic       carry;
  } stageCtrl_t;

  // Only the defined opcodes are allowed to touch the condition codes.
  function automatic logic updatesCc(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU evaluator: op, a, b -> result, carry, err.
// Unknown opcodes pass a through and raise err.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             err_o
);

  logic [WIDTH:0]          sum;
  logic signed [WIDTH-1:0] shrResult;

  assign sum       = {1'b0, a_i} + {1'b0, b_i};
  assign shrResult = $signed(a_i) >>> b_i;

  always_comb begin
    result_o = a_i;
    carry_o  = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
      end
      OP_AND: result_o = a_i & b_i;
      OP_ANY: result_o = {{(WIDTH-1){1'b0}}, |a_i};
      OP_OR:  result_o = a_i | b_i;
      // Oversized shift counts saturate to a full sign fill.
      OP_SHR: result_o = (b_i >= WIDTH'(WIDTH)) ? {WIDTH{a_i[WIDTH-1]}} : shrResult;
      OP_XOR: result_o = a_i ^ b_i;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, flush and tag passthrough.
// Define ALU_PIPE_CC_EN to keep the condition-code register; otherwise cc_o reads 0.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int TAG_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o,
  output logic [2:0]       cc_o
);

`ifdef ALU_PIPE_CC_EN
  localparam logic CarryKeep = 1'b1;
`else
  localparam logic CarryKeep = 1'b0;
`endif

  logic [WIDTH-1:0]  coreResult;
  logic              coreCarry;
  logic              coreErr;

  stageCtrl_t        ctrl_q   [STAGES];
  stageCtrl_t        ctrl_d   [STAGES];
  logic [WIDTH-1:0]  result_q [STAGES];
  logic [WIDTH-1:0]  result_d [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [TAG_W-1:0]  tag_d    [STAGES];

  logic [STAGES-1:0] advance;
  logic              retire;
  logic              accept;
  stageCtrl_t        newCtrl;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (in_op_i),
    .a_i      (in_a_i),
    .b_i      (in_b_i),
    .result_o (coreResult),
    .carry_o  (coreCarry),
    .err_o    (coreErr)
  );

  assign retire     = ctrl_q[STAGES-1].valid && out_ready_i;
  assign in_ready_o = !flush_i && advance[0];
  assign accept     = in_valid_i && in_ready_o;

  // A stage may move whenever any stage at or beyond it is empty, or the tail retires.
  always_comb begin
    logic hole;
    hole    = retire;
    advance = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      hole       = hole | ~ctrl_q[i].valid;
      advance[i] = hole;
    end
  end

  always_comb begin
    newCtrl.valid = accept;
    newCtrl.op    = in_op_i;
    newCtrl.err   = coreErr;
    newCtrl.carry = coreCarry & CarryKeep;
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      ctrl_d[i]   = ctrl_q[i];
      result_d[i] = result_q[i];
      tag_d[i]    = tag_q[i];
    end
    if (advance[0]) begin
      ctrl_d[0]   = newCtrl;
      result_d[0] = coreResult;
      tag_d[0]    = in_tag_i;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (advance[i]) begin
        ctrl_d[i]   = ctrl_q[i-1];
        result_d[i] = result_q[i-1];
        tag_d[i]    = tag_q[i-1];
      end
    end
    if (flush_i) begin
      for (int i = 0; i < STAGES; i++) begin
        ctrl_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        ctrl_q[i]   <= '0;
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        ctrl_q[i]   <= ctrl_d[i];
        result_q[i] <= result_d[i];
        tag_q[i]    <= tag_d[i];
      end
    end
  end

  assign out_valid_o  = ctrl_q[STAGES-1].valid;
  assign out_result_o = result_q[STAGES-1];
  assign out_tag_o    = tag_q[STAGES-1];
  assign out_err_o    = ctrl_q[STAGES-1].err;

`ifdef ALU_PIPE_CC_EN
  logic [2:0] cc_q;
  logic [2:0] cc_d;

  // Condition codes reflect only results that actually leave the pipe.
  always_comb begin
    cc_d = cc_q;
    if (retire && updatesCc(ctrl_q[STAGES-1].op)) begin
      cc_d[CC_ZERO]  = (result_q[STAGES-1] == '0);
      cc_d[CC_NEG]   = result_q[STAGES-1][WIDTH-1];
      cc_d[CC_CARRY] = ctrl_q[STAGES-1].carry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q <= 3'b000;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc_o = cc_q;
`else
  assign cc_o = 3'b000;
`endif

endmodule
